// File: rtl/ahb_subordinate_synth_pkg.sv
// Shared encodings for the AHB SRAM subordinate: HTRANS/HRESP/HSIZE codes, FSM state codes
// and the byte-lane merge helper used for both commit and read forwarding.
package ahb_subordinate_synth_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef logic [1:0] ahb_state_t;
  localparam ahb_state_t ST_IDLE = 2'd0;
  localparam ahb_state_t ST_WAIT = 2'd1;
  localparam ahb_state_t ST_ERR1 = 2'd2;
  localparam ahb_state_t ST_ERR2 = 2'd3;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] m;
    m = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) m[8*b +: 8] = new_w[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/ahb_byte_lane_mask.sv
// Byte-lane strobe for a transfer from its size and low address bits (little-endian).
// Sizes above word fall back to all lanes; misaligned low bits are ignored.
module ahb_byte_lane_mask
  import ahb_subordinate_synth_pkg::*;
(
  input  logic [2:0] i_hsize,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_strb
);

  always_comb begin
    o_strb = 4'b1111;
    case (i_hsize)
      HSIZE_BYTE: o_strb = 4'b0001 << i_addr_lo;
      HSIZE_HALF: o_strb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    o_strb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahb_subordinate_synth.sv
// AHB-Lite SRAM subordinate with programmable wait states and write-to-read forwarding.
// Define AHB_SUBORDINATE_SYNTH_ERR_EN to get two-cycle ERROR responses for bad transfers.
module ahb_subordinate_synth
  import ahb_subordinate_synth_pkg::*;
#(
  parameter int Depth      = 16,
  parameter int WaitStates = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  // state | meaning
  // IDLE  | ready; completes any pending OKAY data phase, may accept an address phase
  // WAIT  | HREADYOUT low while the wait counter runs down to its terminal count
  // ERR1  | first ERROR cycle, HREADYOUT low
  // ERR2  | second ERROR cycle, HREADYOUT high, may accept an address phase

  localparam int AW = $clog2(Depth);

  ahb_state_t    r_state;
  logic [3:0]    r_cnt;
  logic          r_wr_pend;
  logic          r_dp_read;
  logic [AW-1:0] r_dp_idx;
  logic [3:0]    r_dp_strb;
  logic [31:0]   r_hrdata;
  logic [31:0]   r_mem [Depth];

  logic          w_hreadyout;
  logic          w_accept;
  logic          w_err;
  logic          w_commit;
  logic [AW-1:0] w_idx_a;
  logic [3:0]    w_strb_a;
  logic [31:0]   w_wr_word;
  logic [31:0]   w_rd_word;

  ahb_byte_lane_mask u_lane_mask (
    .i_hsize   (HSIZE),
    .i_addr_lo (HADDR[1:0]),
    .o_strb    (w_strb_a)
  );

  assign w_hreadyout = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign w_accept    = HSEL && HREADY && w_hreadyout &&
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign w_idx_a     = HADDR[AW+1:2];
  assign w_commit    = r_wr_pend && (r_state == ST_IDLE);
  assign w_wr_word   = lane_merge(r_mem[r_dp_idx], HWDATA, r_dp_strb);
  // A read whose address phase overlaps a committing write to the same word sees the merged data.
  assign w_rd_word   = (w_commit && (r_dp_idx == w_idx_a)) ? w_wr_word : r_mem[w_idx_a];

`ifdef AHB_SUBORDINATE_SYNTH_ERR_EN
  assign w_err = (HADDR >= 32'(Depth * 4)) || (HSIZE > HSIZE_WORD) ||
                 ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                 ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
  assign HRESP = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
  logic w_unused_haddr;
  assign w_unused_haddr = ^HADDR[31:AW+2];
  assign w_err = 1'b0;
  assign HRESP = HRESP_OKAY;
`endif

  assign HREADYOUT = w_hreadyout;
  assign HRDATA    = r_hrdata;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_wr_pend <= 1'b0;
      r_dp_read <= 1'b0;
      r_dp_idx  <= '0;
      r_dp_strb <= '0;
    end else begin
      if (w_commit) r_wr_pend <= 1'b0;
      case (r_state)
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= ST_IDLE;
        end
`ifdef AHB_SUBORDINATE_SYNTH_ERR_EN
        ST_ERR1: r_state <= ST_ERR2;
`endif
        default: begin
          r_state <= ST_IDLE;
          if (w_accept && w_err) begin
            r_state <= ST_ERR1;
          end else if (w_accept) begin
            r_wr_pend <= HWRITE;
            r_dp_read <= !HWRITE;
            r_dp_idx  <= w_idx_a;
            r_dp_strb <= w_strb_a;
            if (WaitStates > 0) begin
              r_state <= ST_WAIT;
              r_cnt   <= 4'(WaitStates);
            end
          end
        end
      endcase
    end
  end

  // Read data is loaded on the edge that opens the HREADYOUT=1 cycle, so it holds otherwise.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hrdata <= '0;
    end else if (w_accept && !w_err && !HWRITE && (WaitStates == 0)) begin
      r_hrdata <= w_rd_word;
    end else if ((r_state == ST_WAIT) && (r_cnt == 4'd1) && r_dp_read) begin
      r_hrdata <= r_mem[r_dp_idx];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[r_dp_idx] <= w_wr_word;
    end
  end

endmodule
